// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: bus widths,
// default RAM depth and the FSM state encoding.
package dmem_ctrl_pkg;

  localparam int DATA_BUS_W      = 32;
  localparam int DATA_ADDR_BUS_W = 32;
  localparam int DMEM_DEPTH_LOG2 = 10;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// MEM-stage memory request bus between the core (master) and the
// data-memory controller (slave).
interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;

  logic                       mem_ce_i;
  logic                       mem_we_i;
  logic [3:0]                 mem_sel_i;
  logic [DATA_ADDR_BUS_W-1:0] mem_addr_i;
  logic [DATA_BUS_W-1:0]      mem_data_i;
  logic [DATA_BUS_W-1:0]      mem_data_o;
  logic                       stallreq_o;
  logic                       addr_err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  mem_data_o, stallreq_o, addr_err_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output mem_data_o, stallreq_o, addr_err_o
  );

endinterface

// File: rtl/dmem_ctrl_ram.sv
// Single-port word RAM with per-byte write enables and a registered
// read port. Contents are never reset; the read register only loads
// on an enabled read so it holds the last read word.
module dmem_ram
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_BUS_W-1:0] wdata,
  output logic [DATA_BUS_W-1:0] rdata
);

  logic [DATA_BUS_W-1:0] mem [2**DEPTH_LOG2];

  // Byte-enabled write, or full-word registered read when no byte is written.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one MEM-stage request at a time,
// holds the pipeline stalled for 1+WAIT_CYCLES cycles, then presents
// the read word and error flag for exactly one DONE cycle.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2  = DMEM_DEPTH_LOG2,
  parameter int WAIT_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  dmem_state_t                state;
  logic [3:0]                 cnt;
  logic                       rd_zero;
  logic                       addr_err;

  logic                       we_p0;
  logic [3:0]                 sel_p0;
  logic [DATA_ADDR_BUS_W-1:0] addr_p0;
  logic [DATA_BUS_W-1:0]      wdata_p0;

  logic                       exec;
  logic                       x_we;
  logic [3:0]                 x_sel;
  logic [DATA_ADDR_BUS_W-1:0] x_addr;
  logic [DATA_BUS_W-1:0]      x_wdata;
  logic                       x_err;
  logic [DATA_BUS_W-1:0]      ram_rdata;

  // Misaligned halfword/word, empty byte mask, or address beyond the RAM.
  function automatic logic access_err(input logic [3:0] sel,
                                      input logic [DATA_ADDR_BUS_W-1:0] addr);
    logic err;
    err = (sel == 4'b0000);
    if (sel == 4'b1111 && addr[1:0] != 2'b00) err = 1'b1;
    if ((sel == 4'b0011 || sel == 4'b1100) && addr[0]) err = 1'b1;
    if ((addr >> (DEPTH_LOG2 + 2)) != '0) err = 1'b1;
    return err;
  endfunction

  // Select which request executes this edge: live inputs when there are no
  // wait states, otherwise the copy latched in IDLE.
  always_comb begin
    exec    = 1'b0;
    x_we    = we_p0;
    x_sel   = sel_p0;
    x_addr  = addr_p0;
    x_wdata = wdata_p0;
    if (state == DMEM_IDLE && bus.mem_ce_i && WAIT_CYCLES == 0) begin
      exec    = 1'b1;
      x_we    = bus.mem_we_i;
      x_sel   = bus.mem_sel_i;
      x_addr  = bus.mem_addr_i;
      x_wdata = bus.mem_data_i;
    end else if (state == DMEM_BUSY && bus.mem_ce_i && cnt == 4'd1) begin
      exec = 1'b1;
    end
  end

  assign x_err = access_err(x_sel, x_addr);

  dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .en    (exec && !x_err),
    .we    (x_we ? x_sel : 4'b0000),
    .idx   (x_addr[DEPTH_LOG2+1:2]),
    .wdata (x_wdata),
    .rdata (ram_rdata)
  );

  // FSM, wait counter and completion status (read-data zeroing, error flag).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DMEM_IDLE;
      cnt      <= 4'd0;
      rd_zero  <= 1'b1;
      addr_err <= 1'b0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (bus.mem_ce_i) begin
            cnt   <= 4'(WAIT_CYCLES);
            state <= (WAIT_CYCLES == 0) ? DMEM_DONE : DMEM_BUSY;
          end
        end
        DMEM_BUSY: begin
          if (!bus.mem_ce_i) begin
            state <= DMEM_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= DMEM_DONE;
          end
        end
        DMEM_DONE: state <= DMEM_IDLE;
        default:   state <= DMEM_IDLE;
      endcase
      if (exec) begin
        addr_err <= x_err;
        if (!x_we) rd_zero <= x_err;
      end
    end
  end

  // Request latch: sampled only when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state == DMEM_IDLE && bus.mem_ce_i) begin
      we_p0    <= bus.mem_we_i;
      sel_p0   <= bus.mem_sel_i;
      addr_p0  <= bus.mem_addr_i;
      wdata_p0 <= bus.mem_data_i;
    end
  end

  assign bus.mem_data_o = rd_zero ? '0 : ram_rdata;
  assign bus.addr_err_o = addr_err;
  assign bus.stallreq_o = rst && ((state == DMEM_IDLE && bus.mem_ce_i) ||
                                  state == DMEM_BUSY);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with two wait states, one with none,
// both checked against a word-array reference model.
module tb_dmem_ctrl;

  logic clk;
  logic rst_a, rst_b;
  int   total, bad;

  logic        ce_v   [2];
  logic        we_v   [2];
  logic [3:0]  sel_v  [2];
  logic [31:0] addr_v [2];
  logic [31:0] wd_v   [2];
  logic        stall_s[2];
  logic        err_s  [2];
  logic [31:0] rd_s   [2];

  logic [31:0] mdl [2][16];

  dmem_ctrl_if bus_a ();
  dmem_ctrl_if bus_b ();

  assign bus_a.mem_ce_i   = ce_v[0];
  assign bus_a.mem_we_i   = we_v[0];
  assign bus_a.mem_sel_i  = sel_v[0];
  assign bus_a.mem_addr_i = addr_v[0];
  assign bus_a.mem_data_i = wd_v[0];
  assign bus_b.mem_ce_i   = ce_v[1];
  assign bus_b.mem_we_i   = we_v[1];
  assign bus_b.mem_sel_i  = sel_v[1];
  assign bus_b.mem_addr_i = addr_v[1];
  assign bus_b.mem_data_i = wd_v[1];
  assign stall_s[0] = bus_a.stallreq_o;
  assign stall_s[1] = bus_b.stallreq_o;
  assign err_s[0]   = bus_a.addr_err_o;
  assign err_s[1]   = bus_b.addr_err_o;
  assign rd_s[0]    = bus_a.mem_data_o;
  assign rd_s[1]    = bus_b.mem_data_o;

  dmem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  dmem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Error rules: empty mask, beyond 1024 words, misaligned word or halfword.
  function automatic bit exp_err(input logic [3:0] sel, input logic [31:0] addr);
    if (sel == 4'd0) return 1'b1;
    if (addr >= 32'd4096) return 1'b1;
    if (sel == 4'd15 && addr % 4 != 0) return 1'b1;
    if ((sel == 4'd3 || sel == 4'd12) && addr % 2 != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One complete request; starts and ends just after a rising edge in IDLE.
  task automatic access(input int d, input bit we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input string nm);
    int          cyc;
    bit          done;
    bit          e_err;
    logic [31:0] e_rd;
    int          w;
    e_err = exp_err(sel, addr);
    w     = int'(addr[5:2]);
    e_rd  = e_err ? 32'd0 : mdl[d][w];
    ce_v[d] = 1'b1; we_v[d] = we; sel_v[d] = sel; addr_v[d] = addr; wd_v[d] = wd;
    cyc = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (stall_s[d]) cyc++;
      else done = 1'b1;
    end
    total++;
    if (!done || cyc != 1 + wait_of(d)) begin
      bad++;
      $display("FAIL %s stall_cycles dut%0d: got %0d want %0d (done=%0d)",
               nm, d, cyc, 1 + wait_of(d), done);
    end
    total++;
    if (err_s[d] !== e_err) begin
      bad++;
      $display("FAIL %s addr_err dut%0d: got %0b want %0b", nm, d, err_s[d], e_err);
    end
    if (!we) begin
      total++;
      if (rd_s[d] !== e_rd) begin
        bad++;
        $display("FAIL %s rdata dut%0d addr=%h: got %h want %h", nm, d, addr, rd_s[d], e_rd);
      end
    end
    ce_v[d] = 1'b0;
    if (we && !e_err) begin
      for (int i = 0; i < 4; i++)
        if (sel[i]) mdl[d][w][8*i +: 8] = wd[8*i +: 8];
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    ce_v[0] = 1'b1;
    @(negedge clk);
    total++;
    if (stall_s[0] !== 1'b0 || rd_s[0] !== 32'd0 || err_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_a: stall=%b data=%h err=%b want 0 0 0", stall_s[0], rd_s[0], err_s[0]);
    end
    total++;
    if (stall_s[1] !== 1'b0 || rd_s[1] !== 32'd0 || err_s[1] !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: stall=%b data=%h err=%b want 0 0 0", stall_s[1], rd_s[1], err_s[1]);
    end
    ce_v[0] = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_and_byte();
    access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "word_write");
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, "word_read");
    access(0, 1'b1, 4'h4, 32'h10, 32'h00AA0000, "byte_write");
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, "byte_read");
    total++;
    if (rd_s[0] !== 32'hDEAABEEF) begin
      bad++;
      $display("FAIL byte_merge: got %h want DEAABEEF", rd_s[0]);
    end
  endtask

  task automatic test_errors();
    access(0, 1'b0, 4'hF, 32'h12, 32'h0, "misaligned_read");
    access(0, 1'b1, 4'h3, 32'h11, 32'h12345678, "misaligned_half_write");
    access(0, 1'b0, 4'hF, 32'h00001000, 32'h0, "range_read");
    access(0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, "empty_sel_write");
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, "after_errors_read");
  endtask

  task automatic init_mem(input int d);
    for (int w = 0; w < 16; w++)
      access(d, 1'b1, 4'hF, 32'(w * 4), $urandom, "init");
  endtask

  task automatic test_abort();
    ce_v[0] = 1'b1; we_v[0] = 1'b1; sel_v[0] = 4'hF;
    addr_v[0] = 32'h20; wd_v[0] = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (stall_s[0] !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_stall: got %b want 1", stall_s[0]);
    end
    ce_v[0] = 1'b0;
    @(negedge clk);
    total++;
    if (stall_s[0] !== 1'b0 || err_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: stall=%b err=%b want 0 0", stall_s[0], err_s[0]);
    end
    @(posedge clk); #1;
    access(0, 1'b0, 4'hF, 32'h20, 32'h0, "abort_word_read");
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] addr;
    logic [3:0]  sel;
    bit          we;
    for (int k = 0; k < n; k++) begin
      addr = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 1) == 0) addr = addr + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | (32'd1 << $urandom_range(12, 31));
      sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) sel = 4'hF;
      we = 1'($urandom_range(0, 1));
      access(d, we, sel, addr, $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    ce_v[1] = 1'b1; we_v[1] = 1'b0; sel_v[1] = 4'hF; addr_v[1] = 32'h0; wd_v[1] = 32'h0;
    @(negedge clk);
    total++;
    if (stall_s[1] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_stall: got %b want 1", stall_s[1]);
    end
    @(negedge clk);
    total++;
    if (stall_s[1] !== 1'b0 || rd_s[1] !== mdl[1][0]) begin
      bad++;
      $display("FAIL b2b_first_done: stall=%b data=%h want 0 %h", stall_s[1], rd_s[1], mdl[1][0]);
    end
    ce_v[1] = 1'b0;
    @(negedge clk);
    total++;
    if (stall_s[1] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got %b want 0", stall_s[1]);
    end
    ce_v[1] = 1'b1; addr_v[1] = 32'h4;
    #1;
    total++;
    if (stall_s[1] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_request: got %b want 1", stall_s[1]);
    end
    @(negedge clk);
    total++;
    if (stall_s[1] !== 1'b0 || rd_s[1] !== mdl[1][1]) begin
      bad++;
      $display("FAIL b2b_second_done: stall=%b data=%h want 0 %h", stall_s[1], rd_s[1], mdl[1][1]);
    end
    ce_v[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall();
    ce_v[1] = 1'b1; we_v[1] = 1'b0; sel_v[1] = 4'hF; addr_v[1] = 32'h8;
    @(negedge clk);
    total++;
    if (stall_s[1] !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_stall: got %b want 1", stall_s[1]);
    end
    #2 rst_b = 1'b0;
    #1;
    total++;
    if (stall_s[1] !== 1'b0 || rd_s[1] !== 32'd0 || err_s[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_stall: stall=%b data=%h err=%b want 0 0 0", stall_s[1], rd_s[1], err_s[1]);
    end
    ce_v[1] = 1'b0;
    #1 rst_b = 1'b1;
    @(posedge clk); #1;
    access(1, 1'b0, 4'hF, 32'h8, 32'h0, "after_reset_read");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ce_v[d] = 1'b0; we_v[d] = 1'b0; sel_v[d] = 4'h0; addr_v[d] = 32'h0; wd_v[d] = 32'h0;
    end
    test_reset();
    test_word_and_byte();
    test_errors();
    init_mem(0);
    test_abort();
    test_random(0, 40);
    init_mem(1);
    test_back_to_back();
    test_reset_mid_stall();
    test_random(1, 30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
